// File: rtl/fifo_flags.sv
// Synchronous FIFO with level flags and sticky overflow/underflow.
// Reset release is re-timed through two flops before operations resume.
module fifo_flags #(
  parameter int width    = 4,
  parameter int height   = 8,
  parameter int af_level = 6,
  parameter int ae_level = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      write,
  input  logic                      read,
  input  logic                      flush,
  input  logic [width-1:0]          data_in,
  output logic [width-1:0]          data_out,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [$clog2(height):0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = $clog2(height);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] HEIGHT = CW'(height);
  localparam logic [CW-1:0] AF_LVL = CW'(af_level);
  localparam logic [CW-1:0] AE_LVL = CW'(ae_level);

  logic [width-1:0] mem [height];

  logic [1:0]       rst_sync_q;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [width-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic en;
  logic rd_ok;
  logic wr_ok;

  // Requests are ignored until release has passed both sync flops.
  assign en = rst_sync_q[1];

  assign full         = (count_q == HEIGHT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);

  assign rd_ok = en && read && !empty && !flush;
  assign wr_ok = en && write && (!full || rd_ok) && !flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      dout_d  = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + AW'(1);
      if (rd_ok) begin
        rptr_d = rptr_q + AW'(1);
        dout_d = mem[rptr_q];
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (en && write && !wr_ok) ovf_d = 1'b1;
      if (en && read && !rd_ok)  unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      dout_q     <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      dout_q     <= dout_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr_q] <= data_in;
  end

  assign data_out  = dout_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fifo_flags.sv
// Directed bench for fifo_flags with default parameters.
module tb_fifo_flags;

  logic       clk = 1'b0;
  logic       rst;
  logic       write, read, flush;
  logic [3:0] data_in;
  logic [3:0] data_out;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;

  int checks = 0;
  int errors = 0;

  fifo_flags dut (
    .clk          (clk),
    .rst          (rst),
    .write        (write),
    .read         (read),
    .flush        (flush),
    .data_in      (data_in),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned obs,
                     input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic w, input logic r, input logic f,
                      input logic [3:0] d);
    write   = w;
    read    = r;
    flush   = f;
    data_in = d;
    @(posedge clk);
    #1;
    write = 1'b0;
    read  = 1'b0;
    flush = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cnt"}, count, 0);
    chk({tag, "_emp"}, empty, 1);
    chk({tag, "_ae"}, almost_empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_af"}, almost_full, 0);
    chk({tag, "_dout"}, data_out, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_unf"}, underflow, 0);
  endtask

  initial begin
    rst = 1'b0;
    write = 1'b0; read = 1'b0; flush = 1'b0; data_in = '0;
    #12;
    chk_reset("rst");
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // fill 1..8
    for (int i = 1; i <= 8; i++) begin
      tick(1, 0, 0, 4'(i));
      chk("fill_cnt", count, i);
      chk("fill_af", almost_full, (i >= 6) ? 1 : 0);
      chk("fill_full", full, (i == 8) ? 1 : 0);
      chk("fill_ae", almost_empty, (i <= 2) ? 1 : 0);
      chk("fill_ovf", overflow, 0);
    end

    // write while full is dropped
    tick(1, 0, 0, 4'd9);
    chk("ovf_cnt", count, 8);
    chk("ovf_flag", overflow, 1);
    for (int i = 1; i <= 8; i++) begin
      tick(0, 1, 0, 4'd0);
      chk("drain_dout", data_out, i);
      chk("drain_cnt", count, 8 - i);
    end
    chk("drain_emp", empty, 1);
    chk("drain_unf", underflow, 0);

    // simultaneous read/write when full, then wrap
    for (int i = 1; i <= 8; i++) tick(1, 0, 0, 4'(i));
    tick(1, 1, 0, 4'd9);
    chk("rw_full_cnt", count, 8);
    chk("rw_full_full", full, 1);
    chk("rw_full_dout", data_out, 1);
    for (int i = 2; i <= 9; i++) begin
      tick(0, 1, 0, 4'd0);
      chk("wrap_dout", data_out, i);
    end
    chk("wrap_emp", empty, 1);

    // simultaneous read/write when empty
    tick(1, 1, 0, 4'd5);
    chk("rw_emp_cnt", count, 1);
    chk("rw_emp_unf", underflow, 1);
    chk("rw_emp_dout", data_out, 9);
    tick(0, 1, 0, 4'd0);
    chk("rw_emp_rd", data_out, 5);
    chk("rw_emp_cnt0", count, 0);

    // flush beats concurrent requests
    tick(1, 0, 0, 4'd10);
    tick(1, 0, 0, 4'd11);
    tick(1, 0, 0, 4'd12);
    chk("pre_fl_cnt", count, 3);
    chk("pre_fl_ovf", overflow, 1);
    chk("pre_fl_unf", underflow, 1);
    tick(1, 1, 1, 4'd13);
    chk("fl_cnt", count, 0);
    chk("fl_emp", empty, 1);
    chk("fl_ovf", overflow, 0);
    chk("fl_unf", underflow, 0);
    chk("fl_dout", data_out, 0);

    // mid-stream asynchronous reset
    for (int i = 1; i <= 5; i++) tick(1, 0, 0, 4'(i));
    tick(0, 1, 0, 4'd0);
    for (int i = 6; i <= 7; i++) tick(1, 0, 0, 4'(i));
    chk("mid_cnt", count, 6);
    chk("mid_dout", data_out, 1);
    tick(0, 1, 0, 4'd0);
    chk("mid_cnt5", count, 5);
    rst = 1'b0;
    #1;
    chk_reset("arst");
    repeat (3) @(posedge clk);
    #1;
    chk_reset("hold");
    @(negedge clk) rst = 1'b1;
    write = 1'b1;
    data_in = 4'd3;
    @(posedge clk);
    #1;
    write = 1'b0;
    chk("sync_cnt", count, 0);
    repeat (2) @(posedge clk);
    #1;
    tick(1, 0, 0, 4'd7);
    chk("post_cnt", count, 1);
    tick(0, 1, 0, 4'd0);
    chk("post_dout", data_out, 7);
    chk("post_emp", empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_flags.md
FIFO_FLAGS -- requirements
Module: fifo_flags

Interface
REQ-001 Parameter width, default 4: data word width in bits, >= 1.
REQ-002 Parameter height, default 8: storage depth in words, power of two, >= 2.
REQ-003 Parameter af_level, default 6: almost_full threshold in words, 1..height-1.
REQ-004 Parameter ae_level, default 2: almost_empty threshold in words, 1..height-1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 write  input  1  write request; data_in captured when accepted.
REQ-008 read  input  1  read request.
REQ-009 flush  input  1  synchronous clear of contents and sticky flags.
REQ-010 data_in  input  width  write data.
REQ-011 data_out  output  width  registered read data.
REQ-012 full  output  1  count == height.
REQ-013 empty  output  1  count == 0.
REQ-014 almost_full  output  1  count >= af_level.
REQ-015 almost_empty  output  1  count <= ae_level.
REQ-016 count  output  $clog2(height)+1  words stored.
REQ-017 overflow  output  1  sticky: a write was dropped.
REQ-018 underflow  output  1  sticky: a read was rejected.

Function
REQ-019 Storage SHALL be a circular buffer with read/write pointers of $clog2(height) bits, wrapping from height-1 to 0 with no gap.
REQ-020 Write acceptance SHALL be: write && (!full || read accepted in same cycle) && !flush.
REQ-021 Read acceptance SHALL be: read && !empty && !flush.
REQ-022 Accepted read SHALL load data_out with the head word at that edge (1-cycle latency); data_out SHALL hold its value otherwise.
REQ-023 count SHALL be +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
REQ-024 Simultaneous read+write when full: both accepted, count stays height, full stays 1.
REQ-025 Simultaneous read+write when empty: write accepted, read rejected, underflow set, count becomes 1, data_out unchanged.
REQ-026 Write while full without accepted read: data dropped, storage and count unchanged, overflow set.
REQ-027 Read while empty: data_out unchanged, underflow set.
REQ-028 overflow/underflow SHALL stay 1 until reset or flush.
REQ-029 full, empty, almost_full, almost_empty SHALL be decoded combinationally from registered count only.
REQ-030 flush SHALL take priority over read/write: next edge pointers=0, count=0, overflow=0, underflow=0, data_out=0; requests in that cycle ignored and flag nothing.

Reset
REQ-031 rst low SHALL immediately force pointers=0, count=0, data_out=0, overflow=0, underflow=0, giving empty=1, almost_empty=1, full=0, almost_full=0.
REQ-032 rst assertion mid-operation SHALL discard all stored words; storage array contents need not be cleared.
REQ-033 Deassertion of rst SHALL be synchronised internally (two-flop) so the first accepted operation occurs no earlier than the second rising edge after release.

Verification
REQ-034 Defaults; write 1..8 on 8 consecutive cycles -> count 1..8, almost_full at count 6, full at 8, overflow 0.
REQ-035 Full, write 9 without read -> count 8, overflow 1; then 8 reads -> data_out 1..8 each one cycle after read, empty at end, underflow 0.
REQ-036 Full, read+write 9 same cycle -> count 8, full 1; 8 reads return 2..9, proving pointer wrap.
REQ-037 Empty, read+write 5 same cycle -> count 1, underflow 1, data_out unchanged; next read -> data_out 5.
REQ-038 Count 3 with overflow and underflow set, flush with read+write high -> next cycle count 0, empty 1, both sticky flags 0, data_out 0.
REQ-039 rst low for 3 cycles with count 5 mid-stream -> all outputs at reset values immediately; after release, write 7 then read -> data_out 7.
